// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source compacting result buffers feeding one registered CDB
// through a round-robin grant, with age-based squash on mispredict.

module wb_arb_buf #(
    parameter int DEPTH  = 2,
    parameter int PREG_W = 7,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enq_valid,
    input  logic [PREG_W-1:0] enq_preg,
    input  logic [31:0]       enq_data,
    input  logic [TAG_W-1:0]  enq_tag,
    input  logic [TAG_W-1:0]  rob_head,
    input  logic              mispredict,
    input  logic [TAG_W-1:0]  mispredict_tag,
    input  logic              pop,
    output logic              ready,
    output logic              head_vld,
    output logic [PREG_W-1:0] head_preg,
    output logic [31:0]       head_data,
    output logic [TAG_W-1:0]  head_tag
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PREG_W-1:0] preg;
        logic [31:0]       data;
        logic [TAG_W-1:0]  tag;
    } ent_t;

    ent_t           mem_q [DEPTH];
    ent_t           mem_d [DEPTH];
    ent_t           comp  [DEPTH];
    ent_t           enq_e;
    logic [CW-1:0]  count_q, count_d;
    int             n, m;

    // Ages are taken relative to the ROB head in TAG_W bits so the ring wraps cleanly.
    function automatic logic younger(input logic [TAG_W-1:0] t,
                                     input logic [TAG_W-1:0] head,
                                     input logic [TAG_W-1:0] br);
        logic [TAG_W-1:0] age_t, age_br;
        age_t  = t - head;
        age_br = br - head;
        return age_t > age_br;
    endfunction

    assign ready = count_q < CW'(DEPTH);
    assign enq_e = '{preg: enq_preg, data: enq_data, tag: enq_tag};

    always_comb begin
        n = 0;
        m = 0;
        for (int j = 0; j < DEPTH; j++) begin
            comp[j]  = '0;
            mem_d[j] = '0;
        end
        // Compact survivors toward the head, preserving order.
        for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(count_q) &&
                !(mispredict && younger(mem_q[k].tag, rob_head, mispredict_tag))) begin
                for (int j = 0; j < DEPTH; j++)
                    if (j == n) comp[j] = mem_q[k];
                n++;
            end
        end
        head_vld  = (n > 0);
        head_preg = comp[0].preg;
        head_data = comp[0].data;
        head_tag  = comp[0].tag;

        if (pop && n > 0) begin
            for (int j = 0; j < DEPTH - 1; j++) mem_d[j] = comp[j+1];
            m = n - 1;
        end else begin
            for (int j = 0; j < DEPTH; j++) mem_d[j] = comp[j];
            m = n;
        end

        // A squashed enqueue still handshakes; it is simply not stored.
        if (enq_valid && ready &&
            !(mispredict && younger(enq_tag, rob_head, mispredict_tag))) begin
            for (int j = 0; j < DEPTH; j++)
                if (j == m) mem_d[j] = enq_e;
            m++;
        end
        count_d = CW'(m);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        end else begin
            count_q <= count_d;
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= mem_d[k];
        end
    end
endmodule

module wb_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int DEPTH   = 2,
    parameter int PREG_W  = 7,
    parameter int TAG_W   = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*PREG_W-1:0] src_preg,
    input  logic [NUM_SRC*32-1:0]     src_data,
    input  logic [NUM_SRC*TAG_W-1:0]  src_rob_tag,
    input  logic [TAG_W-1:0]          rob_head,
    input  logic                      mispredict,
    input  logic [TAG_W-1:0]          mispredict_tag,
    output logic                      cdb_valid,
    output logic [PREG_W-1:0]         cdb_preg,
    output logic [31:0]               cdb_data,
    output logic [TAG_W-1:0]          cdb_rob_tag,
    output logic [1:0]                cdb_src
);
    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]             head_vld, pop;
    logic [NUM_SRC-1:0][PREG_W-1:0] head_preg;
    logic [NUM_SRC-1:0][31:0]       head_data;
    logic [NUM_SRC-1:0][TAG_W-1:0]  head_tag;
    logic [PTR_W-1:0]               rr_ptr, gnt_idx;
    logic [PTR_W:0]                 scan;
    logic                           gnt_any;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign pop[g] = gnt_any && (gnt_idx == PTR_W'(g));

        wb_arb_buf #(.DEPTH(DEPTH), .PREG_W(PREG_W), .TAG_W(TAG_W)) u_buf (
            .clk            (clk),
            .reset          (reset),
            .enq_valid      (src_valid[g]),
            .enq_preg       (src_preg[g*PREG_W +: PREG_W]),
            .enq_data       (src_data[g*32 +: 32]),
            .enq_tag        (src_rob_tag[g*TAG_W +: TAG_W]),
            .rob_head       (rob_head),
            .mispredict     (mispredict),
            .mispredict_tag (mispredict_tag),
            .pop            (pop[g]),
            .ready          (src_ready[g]),
            .head_vld       (head_vld[g]),
            .head_preg      (head_preg[g]),
            .head_data      (head_data[g]),
            .head_tag       (head_tag[g])
        );
    end

    // First surviving head at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            scan = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (scan >= (PTR_W+1)'(NUM_SRC)) scan = scan - (PTR_W+1)'(NUM_SRC);
            if (!gnt_any && head_vld[scan[PTR_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = scan[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= '0;
            cdb_valid   <= 1'b0;
            cdb_preg    <= '0;
            cdb_data    <= '0;
            cdb_rob_tag <= '0;
            cdb_src     <= '0;
        end else begin
            cdb_valid <= gnt_any;
            if (gnt_any) begin
                rr_ptr      <= (gnt_idx == PTR_W'(NUM_SRC-1)) ? '0 : gnt_idx + 1'b1;
                cdb_preg    <= head_preg[gnt_idx];
                cdb_data    <= head_data[gnt_idx];
                cdb_rob_tag <= head_tag[gnt_idx];
                cdb_src     <= 2'(gnt_idx);
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: latency, round-robin order, backpressure,
// wrap-around flush, flushed enqueue and mid-operation reset.

module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [20:0] src_preg;
    logic [95:0] src_data;
    logic [14:0] src_rob_tag;
    logic [4:0]  rob_head;
    logic        mispredict;
    logic [4:0]  mispredict_tag;
    logic        cdb_valid;
    logic [6:0]  cdb_preg;
    logic [31:0] cdb_data;
    logic [4:0]  cdb_rob_tag;
    logic [1:0]  cdb_src;

    int n_assert = 0;
    int n_fail   = 0;

    wb_arbiter #(.NUM_SRC(3), .DEPTH(2), .PREG_W(7), .TAG_W(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .src_preg       (src_preg),
        .src_data       (src_data),
        .src_rob_tag    (src_rob_tag),
        .rob_head       (rob_head),
        .mispredict     (mispredict),
        .mispredict_tag (mispredict_tag),
        .cdb_valid      (cdb_valid),
        .cdb_preg       (cdb_preg),
        .cdb_data       (cdb_data),
        .cdb_rob_tag    (cdb_rob_tag),
        .cdb_src        (cdb_src)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cdb_chk(input string tag, input logic v, input logic [1:0] s,
                           input logic [4:0] t);
        chk({tag, ".valid"}, 64'(cdb_valid), 64'(v));
        if (v) begin
            chk({tag, ".src"}, 64'(cdb_src), 64'(s));
            chk({tag, ".tag"}, 64'(cdb_rob_tag), 64'(t));
        end
    endtask

    task automatic put(input int i, input logic [6:0] p, input logic [31:0] d,
                       input logic [4:0] t);
        src_valid[i]          = 1'b1;
        src_preg[i*7 +: 7]    = p;
        src_data[i*32 +: 32]  = d;
        src_rob_tag[i*5 +: 5] = t;
    endtask

    initial begin
        reset = 1'b1;
        src_valid = '0; src_preg = '0; src_data = '0; src_rob_tag = '0;
        rob_head = '0; mispredict = 1'b0; mispredict_tag = '0;
        tick(); tick();
        chk("rst.cdb_valid", 64'(cdb_valid), 64'd0);
        chk("rst.cdb_all", {cdb_preg, cdb_data, cdb_rob_tag, cdb_src}, 64'd0);
        reset = 1'b0;
        tick();
        chk("rst.ready", 64'(src_ready), 64'b111);

        // Single source: accepted at edge 0, broadcast after edge 1.
        put(0, 7'd5, 32'h11, 5'd3);
        tick();
        src_valid = '0;
        cdb_chk("single.e0", 1'b0, 2'd0, 5'd0);
        tick();
        cdb_chk("single.e1", 1'b1, 2'd0, 5'd3);
        chk("single.preg", 64'(cdb_preg), 64'd5);
        chk("single.data", 64'(cdb_data), 64'h11);
        tick();
        cdb_chk("single.e2", 1'b0, 2'd0, 5'd0);

        // Round-robin from rr_ptr = 0 (re-reset to guarantee the pointer).
        reset = 1'b1; tick(); reset = 1'b0;
        put(0, 7'd10, 32'hA0, 5'd1);
        put(1, 7'd11, 32'hA1, 5'd2);
        put(2, 7'd12, 32'hA2, 5'd3);
        tick();
        src_valid = '0;
        tick(); cdb_chk("rr.0", 1'b1, 2'd0, 5'd1);
        tick(); cdb_chk("rr.1", 1'b1, 2'd1, 5'd2);
        chk("rr.1.data", 64'(cdb_data), 64'hA1);
        tick(); cdb_chk("rr.2", 1'b1, 2'd2, 5'd3);
        tick(); cdb_chk("rr.idle", 1'b0, 2'd0, 5'd0);
        put(1, 7'd21, 32'hB1, 5'd4);
        put(2, 7'd22, 32'hB2, 5'd5);
        tick();
        src_valid = '0;
        tick(); cdb_chk("rr2.first", 1'b1, 2'd1, 5'd4);
        tick(); cdb_chk("rr2.second", 1'b1, 2'd2, 5'd5);
        tick(); cdb_chk("rr2.idle", 1'b0, 2'd0, 5'd0);

        // Backpressure on memory source while ALU keeps competing (rr_ptr = 0).
        put(0, 7'd30, 32'hC0, 5'd6);
        put(2, 7'd32, 32'hC2, 5'd7);
        tick();
        chk("bp.A.ready", 64'(src_ready), 64'b111);
        cdb_chk("bp.A", 1'b0, 2'd0, 5'd0);
        tick();
        chk("bp.B.ready2", 64'(src_ready[2]), 64'd0);
        cdb_chk("bp.B", 1'b1, 2'd0, 5'd6);
        tick();
        cdb_chk("bp.C", 1'b1, 2'd2, 5'd7);
        chk("bp.C.ready2", 64'(src_ready[2]), 64'd1);
        src_valid = '0;
        tick(); cdb_chk("bp.D", 1'b1, 2'd0, 5'd6);
        tick(); cdb_chk("bp.E", 1'b1, 2'd2, 5'd7);
        tick(); cdb_chk("bp.F", 1'b1, 2'd0, 5'd6);
        tick(); cdb_chk("bp.G", 1'b0, 2'd0, 5'd0);

        // Flush with wrap: head 30, tags 31/1/4, branch tag 1 (rr_ptr = 1).
        rob_head = 5'd30;
        put(0, 7'd40, 32'hD0, 5'd31);
        put(1, 7'd41, 32'hD1, 5'd1);
        put(2, 7'd42, 32'hD2, 5'd4);
        tick();
        src_valid = '0;
        cdb_chk("wrap.H", 1'b0, 2'd0, 5'd0);
        mispredict = 1'b1; mispredict_tag = 5'd1;
        tick();
        mispredict = 1'b0;
        cdb_chk("wrap.I", 1'b1, 2'd1, 5'd1);
        tick();
        cdb_chk("wrap.J", 1'b1, 2'd0, 5'd31);
        chk("wrap.J.data", 64'(cdb_data), 64'hD0);
        tick();
        cdb_chk("wrap.K", 1'b0, 2'd0, 5'd0);

        // Flush coinciding with enqueue of younger tag 9 (rr_ptr = 1).
        rob_head = 5'd0;
        put(0, 7'd50, 32'hE0, 5'd5);
        put(1, 7'd51, 32'hE1, 5'd9);
        mispredict = 1'b1; mispredict_tag = 5'd7;
        chk("flenq.ready", 64'(src_ready), 64'b111);
        tick();
        mispredict = 1'b0;
        src_valid = '0;
        chk("flenq.L.ready", 64'(src_ready), 64'b111);
        cdb_chk("flenq.L", 1'b0, 2'd0, 5'd0);
        tick();
        cdb_chk("flenq.M", 1'b1, 2'd0, 5'd5);
        tick();
        cdb_chk("flenq.N", 1'b0, 2'd0, 5'd0);

        // Load buffers, then reset mid-operation.
        put(0, 7'd60, 32'hF0, 5'd10);
        put(1, 7'd61, 32'hF1, 5'd11);
        put(2, 7'd62, 32'hF2, 5'd12);
        repeat (4) tick();
        chk("mid.notall", 64'(src_ready == 3'b111), 64'd0);
        src_valid = '0;
        reset = 1'b1;
        tick();
        chk("mid.cdb_valid", 64'(cdb_valid), 64'd0);
        chk("mid.cdb_all", {cdb_preg, cdb_data, cdb_rob_tag, cdb_src}, 64'd0);
        chk("mid.ready", 64'(src_ready), 64'b111);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid.stale", 64'(cdb_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback (CDB) arbiter between the three execution units (ALU, branch, memory) and the single shared result broadcast. Each unit deposits completed results into a private shallow buffer. A round-robin scheduler then grants one buffered result per cycle onto the registered CDB. The CDB drives the PRF write port, ROB completion, and RS/dispatch wakeup. Entries younger than a mispredicted branch are squashed in the buffers and on the output, using ROB-tag age relative to the ROB head.

## Interface
- NUM_SRC, 3: number of requesters; index 0 = ALU, 1 = branch, 2 = memory.
- DEPTH, 2: entries per source buffer; legal values 2..4.
- PREG_W, 7: physical register tag width.
- TAG_W, 5: ROB tag width (32-entry ROB).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- src_valid  in  NUM_SRC  source i presents a result this cycle.
- src_ready  out  NUM_SRC  source i buffer can accept; `count_i < DEPTH`.
- src_preg  in  NUM_SRC*PREG_W  destination preg; slice i = `[i*PREG_W +: PREG_W]`.
- src_data  in  NUM_SRC*32  result data; slice i = `[i*32 +: 32]`.
- src_rob_tag  in  NUM_SRC*TAG_W  ROB tag of the result.
- rob_head  in  TAG_W  oldest in-flight ROB tag.
- mispredict  in  1  one-cycle flush pulse.
- mispredict_tag  in  TAG_W  ROB tag of the mispredicted branch.
- cdb_valid  out  1  broadcast valid (registered).
- cdb_preg  out  PREG_W  broadcast preg.
- cdb_data  out  32  broadcast data.
- cdb_rob_tag  out  TAG_W  broadcast ROB tag.
- cdb_src  out  2  index of the granted source.

## Operation
**Accept**
- An enqueue to buffer i occurs at the edge where `src_valid[i] && src_ready[i]`.
- `src_ready` depends only on `count`. A full buffer is not ready, even if it is dequeued in the same cycle.
- Each buffer is an in-order FIFO with its own count.

**Select**
- The candidates are the non-empty buffer heads.
- The grant is the first candidate at or after `rr_ptr`, scanning upward modulo NUM_SRC.
- On a grant, the granted head is popped and `rr_ptr` becomes granted+1 (mod NUM_SRC).
- When no candidate exists, `rr_ptr` holds.

**CDB**
- At each edge the output register loads the granted head with `cdb_valid = 1`, or `cdb_valid = 0` if there is no grant.
- The CDB is never back-pressured.

**Age**
- `age(t) = (t - rob_head) mod 2^TAG_W`, computed in TAG_W bits so that wrap-around is handled.
- Entry e is younger than the branch iff `age(e.tag) > age(mispredict_tag)`.

**Flush** (applies in the cycle `mispredict` = 1)
- Every buffered entry younger than the branch is removed. Survivors keep their relative order and are compacted toward the head, and counts are updated.
- A same-cycle enqueue whose tag is younger is dropped, although its handshake still completes.
- The grant for that cycle is computed only over surviving heads, so no younger entry reaches the CDB.
- The branch itself (`tag == mispredict_tag`) and all older entries are kept.
- The CDB value already registered in this cycle is not retracted.
- `rr_ptr` is unaffected by a flush.

**Reset**
- Reset empties all buffers and sets `rr_ptr = 0`.
- Reset clears `cdb_valid`, `cdb_preg`, `cdb_data`, `cdb_rob_tag` and `cdb_src` to 0.
- `src_ready` is all ones one cycle after reset is released.
- A reset asserted mid-operation discards all buffered results.

## Timing
- Latency: a result accepted at edge N is broadcast at the earliest after edge N+1, i.e. `cdb_valid` = 1 in cycle N+1, provided it wins arbitration.
- There is no combinational path from `src_*` to `cdb_*`.
- Throughput is one broadcast per cycle in aggregate.
- Any continuously non-empty source is granted at least once every NUM_SRC cycles.
- Simultaneous enqueue and dequeue on the same buffer leaves its count unchanged.
- An enqueue into an empty buffer cannot be granted in the same cycle; the head is only visible after the edge.
- `mispredict` and `rob_head` are sampled at the same edge as the enqueue/dequeue. Flush, enqueue, pop and compaction resolve together at that edge.

## Test plan
- **Single source:** ALU presents preg 5, data 0x11, tag 3 at edge 0.
  - Required: `cdb_valid` = 1 with preg 5, data 0x11, tag 3, `src` 0 in the cycle after edge 1, then `cdb_valid` = 0.
- **Round-robin:** all three sources enqueue one entry at the same edge with `rr_ptr` = 0.
  - Required: broadcasts in order src 0, 1, 2 on three consecutive cycles.
  - Then src 1 and src 2 enqueue again: src 1 goes before src 2.
- **Full / backpressure:** hold `src_valid[2]` high with DEPTH = 2 while ALU traffic continuously starves grants to src 2.
  - Required: `src_ready[2]` = 0 after two accepts.
  - Required: src 2 is still granted within 3 cycles, and `src_ready[2]` returns to 1 the cycle after its pop.
- **Flush with wrap:** `rob_head` = 30; buffers hold tags 31, 1, 4; `mispredict_tag` = 1.
  - Required: tag 4 is removed, tags 31 and 1 survive and are broadcast, and tag 4 never appears on the CDB.
- **Flush with same-cycle enqueue:** `mispredict` coincides with an enqueue of tag 9 while `mispredict_tag` = 7 and `rob_head` = 0.
  - Required: `src_ready` handshake completes, the count is unchanged, and tag 9 is never broadcast.
- **Reset mid-operation:** assert reset with all buffers full.
  - Required: the next cycle has all `cdb_*` = 0 and `src_ready` = 3'b111, and no stale entry is ever broadcast afterward.
